sr_button_conditioner: RTL and testbench
========================================

# sr_button_conditioner

Front-end conditioner that turns two raw, bouncing push-button inputs into clean set/reset drives for the SR latch stage. Each button is synchronised into the clock domain, debounced by a per-channel counter state machine, and arbitrated so the downstream latch never sees the illegal S=R=1 combination. It sits directly upstream of the latch, and its S and R outputs connect straight to the latch's S and R inputs.

## Interface
- `DEBOUNCE_CYCLES`, default 8: consecutive stable synchronised samples required to accept a press or a release. Legal range is 2 to 65535.
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `btn_set`  in  1  raw set button, asynchronous and bouncing; 1 = pressed.
- `btn_reset`  in  1  raw reset button, asynchronous and bouncing; 1 = pressed.
- `S`  out  1  registered set drive to the latch.
- `R`  out  1  registered reset drive to the latch.
- `set_db`  out  1  registered debounced level of the set button, before arbitration.
- `reset_db`  out  1  registered debounced level of the reset button, before arbitration.

## Operation
- **Synchroniser.** Each button passes through a 2-flop synchroniser. The second flop output is `sb`.
- **Per-channel FSM.** Each channel has four states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. Each channel has its own counter `cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`.
  - IDLE: if `sb`=1, go to PRESS_WAIT with `cnt`=1.
  - PRESS_WAIT: if `sb`=0, go to IDLE with `cnt`=0. Else if `cnt`==DEBOUNCE_CYCLES-1, go to PRESSED with `cnt`=0. Else increment `cnt`.
  - PRESSED: if `sb`=0, go to RELEASE_WAIT with `cnt`=1.
  - RELEASE_WAIT: if `sb`=1, go to PRESSED with `cnt`=0. Else if `cnt`==DEBOUNCE_CYCLES-1, go to IDLE with `cnt`=0. Else increment `cnt`.
- **Debounced level.** The debounced level is 1 in PRESSED and RELEASE_WAIT, and 0 otherwise. It is registered onto `set_db` / `reset_db`.
- **Glitch rejection.** Any bounce shorter than DEBOUNCE_CYCLES synchronised samples leaves the debounced level unchanged. The counter restarts from the beginning on every bounce.
- **Arbitration (reset dominates).** Next `S` = set level AND NOT reset level. Next `R` = reset level.
  - Both pressed: S=0, R=1.
  - `{S,R}` never equals 2'b11 in any cycle, including across simultaneous transitions.
- **Reset.** Every output is 0 in the cycle after a `reset` edge: `S`=0, `R`=0, `set_db`=0, `reset_db`=0. Internally: sync flops 0, both FSMs in IDLE, counters 0.
  - Reset asserted mid-count or while PRESSED aborts immediately.
  - A button still held after reset deasserts is re-debounced from IDLE.

## Timing
- **Press latency.** Raw input goes high and stays high before edge 0. Then `sb`=1 after edge 1, and the FSM enters PRESSED at edge DEBOUNCE_CYCLES+1. `set_db`/`reset_db` and `S`/`R` both update at edge DEBOUNCE_CYCLES+2, i.e. DEBOUNCE_CYCLES+2 edges after the input change.
- **Release latency.** Identical to press latency, DEBOUNCE_CYCLES+2 edges.
- **Minimum accepted pulse.** A raw pulse is accepted only if it is stable for DEBOUNCE_CYCLES consecutive samples of `sb`.
- **Simultaneous events.** The two channels are fully independent until arbitration. Arbitration acts on the same-cycle debounced levels, with no extra latency.
- **Reset timing.** `reset` is sampled at each edge and overrides all other inputs.

## Configuration
- Macro `SR_CONDITIONER_PULSE_EN`.
- **Not defined (default): level mode.** `S`/`R` follow the arbitrated debounced levels as described above.
- **Defined: pulse mode.** `S` and `R` are single-cycle pulses instead of levels.
  - `S` pulses for exactly one cycle on a rising edge of the set level while the reset level is 0.
  - `R` pulses for exactly one cycle on a rising edge of the reset level.
  - If both levels rise in the same cycle, only `R` pulses.
  - Releases produce no pulse.
  - `set_db`/`reset_db` are unchanged from level mode.
  - Timing: each pulse appears at the same edge where level mode would raise the output.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.

1. **Reset.** Assert `reset` for 2 cycles with both buttons at 1 → `S`,`R`,`set_db`,`reset_db` all 0. After deassert, `S`=1 after 6 edges.
2. **Clean press/release.** Raise `btn_set` for 20 cycles → `S` rises exactly 6 edges after the input change and falls exactly 6 edges after release. `R` stays 0 throughout.
3. **Bounce rejection.** Drive `btn_reset` with the pattern 1,0,1,1,0,1,1,1,1,1… → `R` rises only 6 edges after the final sustained 1. A 3-cycle pulse alone leaves `R`=0.
4. **Simultaneous press.** Raise both buttons on the same cycle → `R`=1 and `S`=0 at edge 6. Release `btn_reset` only → `S`=1 and `R`=0 6 edges later. `{S,R}` never equals 11.
5. **Mid-count reset.** Raise `btn_set`, then assert `reset` at edge 4 → outputs stay 0. Holding the button after reset deasserts yields `S`=1 exactly 6 edges after deassert.
6. **Pulse mode.** With `SR_CONDITIONER_PULSE_EN` defined, repeat scenario 2 → `S` high for exactly 1 cycle at edge 6 and no pulse on release. Repeat scenario 4 → a single `R` pulse and no `S` pulse.

Source files
------------

// File: rtl/sr_button_conditioner.sv
// Conditions two raw bouncing buttons into S/R drives for a downstream SR latch, with reset dominating.
// Define SR_CONDITIONER_PULSE_EN for single-cycle S/R pulses on debounced presses instead of levels.
module sr_button_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_set,
   input  logic btn_reset,
   output logic S,
   output logic R,
   output logic set_db,
   output logic reset_db
);

   localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } db_state_t;

   // Channel 0 is the set button, channel 1 the reset button.
   logic [1:0]    sync_a;
   logic [1:0]    sb;
   db_state_t     state_q [2];
   db_state_t     state_d [2];
   logic [CW-1:0] cnt_q   [2];
   logic [CW-1:0] cnt_d   [2];
   logic [1:0]    lvl;
   logic          s_next;
   logic          r_next;

   always_comb begin
      for (int unsigned ch = 0; ch < 2; ch++) begin
         state_d[ch] = state_q[ch];
         cnt_d[ch]   = cnt_q[ch];
         lvl[ch]     = 1'b0;
         case (state_q[ch])
            IDLE: begin
               if (sb[ch]) begin
                  state_d[ch] = PRESS_WAIT;
                  cnt_d[ch]   = CW'(1);
               end
            end
            PRESS_WAIT: begin
               if (!sb[ch]) begin
                  state_d[ch] = IDLE;
                  cnt_d[ch]   = '0;
               end else if (cnt_q[ch] == CNT_LAST) begin
                  state_d[ch] = PRESSED;
                  cnt_d[ch]   = '0;
               end else begin
                  cnt_d[ch] = cnt_q[ch] + 1'b1;
               end
            end
            PRESSED: begin
               lvl[ch] = 1'b1;
               if (!sb[ch]) begin
                  state_d[ch] = RELEASE_WAIT;
                  cnt_d[ch]   = CW'(1);
               end
            end
            RELEASE_WAIT: begin
               lvl[ch] = 1'b1;
               if (sb[ch]) begin
                  state_d[ch] = PRESSED;
                  cnt_d[ch]   = '0;
               end else if (cnt_q[ch] == CNT_LAST) begin
                  state_d[ch] = IDLE;
                  cnt_d[ch]   = '0;
               end else begin
                  cnt_d[ch] = cnt_q[ch] + 1'b1;
               end
            end
            default: begin
               state_d[ch] = IDLE;
               cnt_d[ch]   = '0;
            end
         endcase
      end
   end

`ifdef SR_CONDITIONER_PULSE_EN
   // Rising edge = current level high while the registered level is still low.
   always_comb begin
      s_next = lvl[0] & ~set_db & ~lvl[1];
      r_next = lvl[1] & ~reset_db;
   end
`else
   always_comb begin
      s_next = lvl[0] & ~lvl[1];
      r_next = lvl[1];
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_a   <= '0;
         sb       <= '0;
         for (int unsigned ch = 0; ch < 2; ch++) begin
            state_q[ch] <= IDLE;
            cnt_q[ch]   <= '0;
         end
         set_db   <= 1'b0;
         reset_db <= 1'b0;
         S        <= 1'b0;
         R        <= 1'b0;
      end else begin
         sync_a   <= {btn_reset, btn_set};
         sb       <= sync_a;
         for (int unsigned ch = 0; ch < 2; ch++) begin
            state_q[ch] <= state_d[ch];
            cnt_q[ch]   <= cnt_d[ch];
         end
         set_db   <= lvl[0];
         reset_db <= lvl[1];
         S        <= s_next;
         R        <= r_next;
      end
   end

endmodule

// File: tb/tb_sr_button_conditioner.sv
// Directed bench for sr_button_conditioner with DEBOUNCE_CYCLES=4; edge 0 is the first edge sampling a new input.
// Expectations follow level mode, or pulse mode when SR_CONDITIONER_PULSE_EN is defined.
module tb_sr_button_conditioner;

   localparam int unsigned DB = 4;
`ifdef SR_CONDITIONER_PULSE_EN
   localparam bit PULSE = 1'b1;
`else
   localparam bit PULSE = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic btn_set;
   logic btn_reset;
   logic S;
   logic R;
   logic set_db;
   logic reset_db;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   sr_button_conditioner #(.DEBOUNCE_CYCLES(DB)) dut (
      .clk      (clk),
      .reset    (reset),
      .btn_set  (btn_set),
      .btn_reset(btn_reset),
      .S        (S),
      .R        (R),
      .set_db   (set_db),
      .reset_db (reset_db)
   );

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %b expected %b", tag, $time, got, exp);
      end
   endtask

   // Advance past one rising edge and confirm the latch never sees S=R=1.
   task automatic step();
      @(posedge clk);
      #1;
      check("sr_never_11", {3'b000, S & R}, 4'b0000);
   endtask

   // Expected vector order: {S, R, set_db, reset_db}.
   task automatic expect_out(input string tag, input logic [3:0] exp);
      check(tag, {S, R, set_db, reset_db}, exp);
   endtask

   logic pat [14] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                      1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

   initial begin
      logic s_e, r_e, sdb_e, rdb_e;

      // 1. Reset with both buttons pressed, then release reset keeping only set held.
      reset     = 1'b1;
      btn_set   = 1'b1;
      btn_reset = 1'b1;
      step();
      step();
      expect_out("reset_all_zero", 4'b0000);
      reset     = 1'b0;
      btn_reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         sdb_e = (i >= 6);
         s_e   = PULSE ? (i == 6) : sdb_e;
         expect_out("post_reset_set", {s_e, 1'b0, sdb_e, 1'b0});
      end
      btn_set = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         sdb_e = (i < 6);
         s_e   = PULSE ? 1'b0 : sdb_e;
         expect_out("post_reset_release", {s_e, 1'b0, sdb_e, 1'b0});
      end

      // 2. Clean 20-cycle press and release of btn_set.
      btn_set = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         sdb_e = (i >= 6);
         s_e   = PULSE ? (i == 6) : sdb_e;
         expect_out("clean_press", {s_e, 1'b0, sdb_e, 1'b0});
      end
      btn_set = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         sdb_e = (i < 6);
         s_e   = PULSE ? 1'b0 : sdb_e;
         expect_out("clean_release", {s_e, 1'b0, sdb_e, 1'b0});
      end

      // 3. Bouncing reset button; final sustained 1 starts at edge 5 so R rises at edge 11.
      for (int i = 0; i < 15; i++) begin
         btn_reset = (i < 14) ? pat[i] : 1'b1;
         step();
         rdb_e = (i >= 11);
         r_e   = PULSE ? (i == 11) : rdb_e;
         expect_out("bounce_press", {1'b0, r_e, 1'b0, rdb_e});
      end
      btn_reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         rdb_e = (i < 6);
         r_e   = PULSE ? 1'b0 : rdb_e;
         expect_out("bounce_release", {1'b0, r_e, 1'b0, rdb_e});
      end
      for (int i = 0; i < 12; i++) begin
         btn_reset = (i < 3);
         step();
         expect_out("short_pulse_rejected", 4'b0000);
      end

      // 4. Simultaneous press: reset dominates; releasing reset hands over to set.
      btn_set   = 1'b1;
      btn_reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         sdb_e = (i >= 6);
         r_e   = PULSE ? (i == 6) : sdb_e;
         expect_out("both_press", {1'b0, r_e, sdb_e, sdb_e});
      end
      btn_reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         rdb_e = (i < 6);
         s_e   = PULSE ? 1'b0 : (i >= 6);
         r_e   = PULSE ? 1'b0 : rdb_e;
         expect_out("reset_release_handover", {s_e, r_e, 1'b1, rdb_e});
      end
      btn_set = 1'b0;
      repeat (8) step();
      expect_out("both_idle", 4'b0000);

      // 5. Reset at edge 4 of a set press; held button is re-debounced from deassert.
      btn_set = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         expect_out("mid_count_pre", 4'b0000);
      end
      reset = 1'b1;
      step();
      expect_out("mid_count_reset", 4'b0000);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         sdb_e = (i >= 6);
         s_e   = PULSE ? (i == 6) : sdb_e;
         expect_out("mid_count_redebounce", {s_e, 1'b0, sdb_e, 1'b0});
      end
      btn_set = 1'b0;
      repeat (8) step();
      expect_out("final_idle", 4'b0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
